pipe_ctrl: RTL and testbench

Parametrised pipeline hazard controller for the yadan core. It generalises the fixed five-stage stall prioritiser to N stages, adds flush generation with deferred (pending) flushes, saturating stall/flush performance counters and a stall watchdog. It sits beside the pipeline registers: it collects per-stage stall requests plus branch/trap flush requests, and drives the per-stage stall and flush vectors every cycle.

---
 rtl/pipe_ctrl_pkg.sv | 28 ++
 rtl/pipe_ctrl_if.sv | 38 +++
 rtl/pipe_ctrl_sat_cnt.sv | 34 +++
 rtl/pipe_ctrl.sv | 127 ++++++++++++
 tb/tb_pipe_ctrl.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// ============================================================================
// Module  : pipe_ctrl_pkg
// Purpose : Shared constants for the pipeline hazard controller.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package pipe_ctrl_pkg;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  localparam int STG_PC  = 0;
  localparam int STG_IF  = 1;
  localparam int STG_ID  = 2;
  localparam int STG_EX  = 3;
  localparam int STG_MEM = 4;

  localparam int DEFAULT_NUM_STAGES = 5;

  // Index width that never collapses to zero bits for tiny parameter values.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_ctrl_if.sv
// ============================================================================
// Module  : pipe_ctrl_if
// Purpose : Request/response bundle between the pipeline and pipe_ctrl.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface pipe_ctrl_if
  import pipe_ctrl_pkg::*;
#(
  parameter int NUM_STAGES = DEFAULT_NUM_STAGES,
  parameter int CNT_W      = 32
);
  localparam int STG_W = idx_width(NUM_STAGES);

  logic [NUM_STAGES-1:0] stallreq_i;
  logic                  flush_req_i;
  logic [STG_W-1:0]      flush_stage_i;
  logic                  cnt_clr_i;
  logic [NUM_STAGES-1:0] stalled_o;
  logic [NUM_STAGES-1:0] flush_o;
  logic [CNT_W-1:0]      stall_cnt_o;
  logic [CNT_W-1:0]      flush_cnt_o;
  logic                  stall_timeout_o;

  modport master (
    output stallreq_i, flush_req_i, flush_stage_i, cnt_clr_i,
    input  stalled_o, flush_o, stall_cnt_o, flush_cnt_o, stall_timeout_o
  );

  modport slave (
    input  stallreq_i, flush_req_i, flush_stage_i, cnt_clr_i,
    output stalled_o, flush_o, stall_cnt_o, flush_cnt_o, stall_timeout_o
  );

endinterface

`default_nettype wire

// File: rtl/pipe_ctrl_sat_cnt.sv
// ============================================================================
// Module  : sat_cnt
// Purpose : Saturating up-counter with synchronous clear (clear wins).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module sat_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr_i) begin
      r_cnt <= '0;
    end else if (inc_i && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt_o = r_cnt;

endmodule

`default_nettype wire

// File: rtl/pipe_ctrl.sv
// ============================================================================
// Module  : pipe_ctrl
// Purpose : N-stage stall prioritiser with deferred flushes, perf counters
//           and a PC-stall watchdog.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int NUM_STAGES = DEFAULT_NUM_STAGES,
  parameter int CNT_W      = 32,
  parameter int WDOG_LIMIT = 1024
) (
  input  logic         clk,
  input  logic         rst,
  pipe_ctrl_if.slave   bus
);

  localparam int                STG_W    = idx_width(NUM_STAGES);
  localparam int                RUN_W    = idx_width(WDOG_LIMIT + 1);
  localparam logic              WDOG_EN  = (WDOG_LIMIT != 0);
  localparam logic [RUN_W-1:0]  RUN_LAST = RUN_W'((WDOG_LIMIT > 0) ? WDOG_LIMIT - 1 : 0);

  logic                  r_pend_v;
  logic [STG_W-1:0]      r_pend_stage;
  logic                  r_timeout;

  logic                  w_fl_req;
  logic [STG_W-1:0]      w_fl_stage;
  logic                  w_blocked;
  logic                  w_fl_eff;
  logic                  w_acc;
  logic [NUM_STAGES-1:0] w_req_masked;
  logic [NUM_STAGES-1:0] w_stalled;
  logic [NUM_STAGES-1:0] w_flush;
  logic [RUN_W-1:0]      w_run_cnt;

  always_comb begin
    w_fl_req     = r_pend_v | bus.flush_req_i;
    w_fl_stage   = r_pend_stage;
    w_blocked    = 1'b0;
    w_req_masked = bus.stallreq_i;
    w_flush      = '0;
    w_stalled    = '0;
    w_acc        = NO_STOP;

    if (bus.flush_req_i && (!r_pend_v || (bus.flush_stage_i > r_pend_stage))) begin
      w_fl_stage = bus.flush_stage_i;
    end

    // Only stalls at or above the flushing stage can hold the flush back.
    for (int s = 0; s < NUM_STAGES; s++) begin
      if (s >= int'(w_fl_stage)) begin
        w_blocked = w_blocked | bus.stallreq_i[s];
      end
    end
    w_fl_eff = w_fl_req & ~w_blocked;

    for (int s = 0; s < NUM_STAGES; s++) begin
      if (w_fl_eff && (s < int'(w_fl_stage))) begin
        w_req_masked[s] = 1'b0;
        w_flush[s]      = 1'b1;
      end
    end

    // Highest requesting stage stalls itself and everything behind it.
    for (int s = NUM_STAGES - 1; s >= 0; s--) begin
      w_acc        = w_acc | w_req_masked[s];
      w_stalled[s] = w_acc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend_v     <= 1'b0;
      r_pend_stage <= '0;
    end else if (w_fl_eff) begin
      r_pend_v     <= 1'b0;
    end else if (w_fl_req) begin
      r_pend_v     <= 1'b1;
      r_pend_stage <= w_fl_stage;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_timeout <= 1'b0;
    end else if (bus.cnt_clr_i) begin
      r_timeout <= 1'b0;
    end else if (WDOG_EN && w_stalled[STG_PC] && (w_run_cnt == RUN_LAST)) begin
      r_timeout <= 1'b1;
    end
  end

  sat_cnt #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (bus.cnt_clr_i),
    .inc_i (|w_stalled),
    .cnt_o (bus.stall_cnt_o)
  );

  sat_cnt #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (bus.cnt_clr_i),
    .inc_i (w_fl_eff),
    .cnt_o (bus.flush_cnt_o)
  );

  sat_cnt #(.W(RUN_W)) u_run_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (~w_stalled[STG_PC]),
    .inc_i (w_stalled[STG_PC]),
    .cnt_o (w_run_cnt)
  );

  assign bus.stalled_o       = rst ? '0 : w_stalled;
  assign bus.flush_o         = rst ? '1 : w_flush;
  assign bus.stall_timeout_o = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
// ============================================================================
// Module  : tb_pipe_ctrl
// Purpose : Directed self-checking bench for pipe_ctrl (N=5, CNT_W=4, L=4).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pipe_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  pipe_ctrl_if #(.NUM_STAGES(5), .CNT_W(4)) bus ();

  pipe_ctrl #(.NUM_STAGES(5), .CNT_W(4), .WDOG_LIMIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [4:0] stall;
    logic       freq;
    logic [2:0] fstg;
    logic [4:0] exp_st;
    logic [4:0] exp_fl;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else passed++;
  endtask

  task automatic drive(input logic [4:0] st, input logic fr, input logic [2:0] fs, input logic clr);
    bus.stallreq_i    = st;
    bus.flush_req_i   = fr;
    bus.flush_stage_i = fs;
    bus.cnt_clr_i     = clr;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_comb(input string nm, input logic [4:0] st, input logic [4:0] fl);
    #1;
    chk({nm, ".stalled"}, 32'(bus.stalled_o), 32'(st));
    chk({nm, ".flush"},   32'(bus.flush_o),   32'(fl));
  endtask

  initial begin
    vecs[0]  = '{5'b00000, 1'b0, 3'd0, 5'b00000, 5'b00000};
    vecs[1]  = '{5'b01000, 1'b0, 3'd0, 5'b01111, 5'b00000};
    vecs[2]  = '{5'b10000, 1'b0, 3'd0, 5'b11111, 5'b00000};
    vecs[3]  = '{5'b00100, 1'b0, 3'd0, 5'b00111, 5'b00000};
    vecs[4]  = '{5'b00000, 1'b0, 3'd0, 5'b00000, 5'b00000};
    vecs[5]  = '{5'b00010, 1'b0, 3'd0, 5'b00011, 5'b00000};
    vecs[6]  = '{5'b00001, 1'b0, 3'd0, 5'b00001, 5'b00000};
    vecs[7]  = '{5'b01010, 1'b0, 3'd0, 5'b01111, 5'b00000};
    vecs[8]  = '{5'b00010, 1'b1, 3'd3, 5'b00000, 5'b00111};
    vecs[9]  = '{5'b00000, 1'b1, 3'd4, 5'b00000, 5'b01111};
    vecs[10] = '{5'b00011, 1'b1, 3'd2, 5'b00000, 5'b00011};
    vecs[11] = '{5'b00000, 1'b1, 3'd0, 5'b00000, 5'b00000};

    // Reset overrides live requests.
    drive(5'b11111, 1'b1, 3'd4, 1'b0);
    #2;
    chk("rst.stalled", 32'(bus.stalled_o), 0);
    chk("rst.flush",   32'(bus.flush_o), 32'h1f);
    chk("rst.scnt",    32'(bus.stall_cnt_o), 0);
    chk("rst.fcnt",    32'(bus.flush_cnt_o), 0);
    chk("rst.tmo",     32'(bus.stall_timeout_o), 0);
    drive(5'b00000, 1'b0, 3'd0, 1'b0);
    cyc();
    rst = 1'b0;
    cyc();

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].stall, vecs[i].freq, vecs[i].fstg, 1'b0);
      chk_comb($sformatf("vec%0d", i), vecs[i].exp_st, vecs[i].exp_fl);
      cyc();
    end
    drive(5'b00000, 1'b0, 3'd0, 1'b0);
    chk("tbl.scnt", 32'(bus.stall_cnt_o), 6);
    chk("tbl.fcnt", 32'(bus.flush_cnt_o), 4);
    chk("tbl.tmo",  32'(bus.stall_timeout_o), 0);

    drive(5'b00000, 1'b0, 3'd0, 1'b1);
    cyc();
    chk("clr.scnt", 32'(bus.stall_cnt_o), 0);
    chk("clr.fcnt", 32'(bus.flush_cnt_o), 0);

    // Flush deferred behind a MEM stall.
    drive(5'b10000, 1'b1, 3'd3, 1'b0);
    chk_comb("def1", 5'b11111, 5'b00000);
    cyc();
    drive(5'b10000, 1'b0, 3'd0, 1'b0);
    chk_comb("def2", 5'b11111, 5'b00000);
    cyc();
    chk_comb("def3", 5'b11111, 5'b00000);
    cyc();
    drive(5'b00000, 1'b0, 3'd0, 1'b0);
    chk_comb("def4", 5'b00000, 5'b00111);
    cyc();
    chk_comb("def5", 5'b00000, 5'b00000);
    cyc();
    chk("def.fcnt", 32'(bus.flush_cnt_o), 1);
    chk("def.scnt", 32'(bus.stall_cnt_o), 3);
    chk("def.tmo",  32'(bus.stall_timeout_o), 0);

    // Pending stage 3 merges with live stage 2.
    drive(5'b01000, 1'b1, 3'd3, 1'b0);
    chk_comb("mrg1", 5'b01111, 5'b00000);
    cyc();
    drive(5'b00000, 1'b1, 3'd2, 1'b0);
    chk_comb("mrg2", 5'b00000, 5'b00111);
    cyc();
    drive(5'b00000, 1'b0, 3'd0, 1'b0);
    chk_comb("mrg3", 5'b00000, 5'b00000);
    cyc();
    chk("mrg.fcnt", 32'(bus.flush_cnt_o), 2);

    // Later, higher blocked request replaces the pending stage.
    drive(5'b10000, 1'b1, 3'd1, 1'b0);
    cyc();
    drive(5'b10000, 1'b1, 3'd3, 1'b0);
    cyc();
    drive(5'b00000, 1'b0, 3'd0, 1'b0);
    chk_comb("rep", 5'b00000, 5'b00111);
    cyc();
    chk("rep.fcnt", 32'(bus.flush_cnt_o), 3);
    chk("rep.scnt", 32'(bus.stall_cnt_o), 6);

    // Watchdog.
    drive(5'b00000, 1'b0, 3'd0, 1'b1);
    cyc();
    drive(5'b00001, 1'b0, 3'd0, 1'b0);
    cyc(); cyc(); cyc();
    chk("wd.3", 32'(bus.stall_timeout_o), 0);
    cyc();
    chk("wd.4", 32'(bus.stall_timeout_o), 1);
    drive(5'b00000, 1'b0, 3'd0, 1'b0);
    cyc(); cyc();
    chk("wd.sticky", 32'(bus.stall_timeout_o), 1);
    drive(5'b00000, 1'b0, 3'd0, 1'b1);
    cyc();
    chk("wd.clr", 32'(bus.stall_timeout_o), 0);
    drive(5'b00001, 1'b0, 3'd0, 1'b0);
    cyc(); cyc(); cyc();
    drive(5'b00001, 1'b0, 3'd0, 1'b1);
    cyc();
    chk("wd.clrwin", 32'(bus.stall_timeout_o), 0);

    // Saturation, then async reset mid-stall with a pending flush.
    drive(5'b00000, 1'b0, 3'd0, 1'b1);
    cyc();
    drive(5'b10000, 1'b0, 3'd0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      if (i == 17) drive(5'b10000, 1'b1, 3'd4, 1'b0);
      else         drive(5'b10000, 1'b0, 3'd0, 1'b0);
      cyc();
    end
    chk("sat.scnt", 32'(bus.stall_cnt_o), 15);
    chk("sat.tmo",  32'(bus.stall_timeout_o), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst.stalled", 32'(bus.stalled_o), 0);
    chk("arst.flush",   32'(bus.flush_o), 32'h1f);
    chk("arst.scnt",    32'(bus.stall_cnt_o), 0);
    chk("arst.fcnt",    32'(bus.flush_cnt_o), 0);
    chk("arst.tmo",     32'(bus.stall_timeout_o), 0);
    drive(5'b00000, 1'b0, 3'd0, 1'b0);
    cyc();
    rst = 1'b0;
    chk_comb("post", 5'b00000, 5'b00000);
    cyc();
    chk("post.fcnt", 32'(bus.flush_cnt_o), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule

`default_nettype wire
